// File: rtl/y86_pkg.sv
// Shared Y86-64 register-file definitions: index constants, default widths and
// clear-engine state encoding.
package y86_pkg;

  localparam int unsigned ADDR_W_DEF = 4;
  localparam int unsigned DATA_W_DEF = 64;

  localparam logic [3:0] RNONE_IDX = 4'hF;

  localparam logic [3:0] RRAX = 4'h0;
  localparam logic [3:0] RRCX = 4'h1;
  localparam logic [3:0] RRDX = 4'h2;
  localparam logic [3:0] RRBX = 4'h3;
  localparam logic [3:0] RRSP = 4'h4;
  localparam logic [3:0] RRBP = 4'h5;
  localparam logic [3:0] RRSI = 4'h6;
  localparam logic [3:0] RRDI = 4'h7;
  localparam logic [3:0] R8   = 4'h8;
  localparam logic [3:0] R9   = 4'h9;
  localparam logic [3:0] R10  = 4'hA;
  localparam logic [3:0] R11  = 4'hB;
  localparam logic [3:0] R12  = 4'hC;
  localparam logic [3:0] R13  = 4'hD;
  localparam logic [3:0] R14  = 4'hE;

  typedef enum logic [1:0] {
    CLR_IDLE  = 2'd0,
    CLR_CLEAR = 2'd1,
    CLR_DONE  = 2'd2
  } clr_state_e;

endpackage

// File: rtl/y86_wr_arbiter.sv
// Fixed-priority selection among write ports targeting one register index;
// the lowest-numbered enabled port that matches wins.
module y86_wr_arbiter
  import y86_pkg::*;
#(
  parameter int unsigned NUM_WR = 2,
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF
) (
  input  logic [NUM_WR-1:0]        i_wr_en,
  input  logic [NUM_WR*ADDR_W-1:0] i_wr_addr,
  input  logic [NUM_WR*DATA_W-1:0] i_wr_data,
  input  logic [ADDR_W-1:0]        i_idx,
  output logic                     o_hit,
  output logic [DATA_W-1:0]        o_data
);

  // Scan from the highest port down so the lowest matching port is applied last.
  always_comb begin
    o_hit  = 1'b0;
    o_data = '0;
    for (int unsigned i = NUM_WR; i > 0; i--) begin
      if (i_wr_en[i-1] && (i_wr_addr[(i-1)*ADDR_W +: ADDR_W] == i_idx)) begin
        o_hit  = 1'b1;
        o_data = i_wr_data[(i-1)*DATA_W +: DATA_W];
      end
    end
  end

endmodule

// File: rtl/y86_regfile_mp.sv
// Multi-port Y86-64 register file with priority writes, optional write-to-read
// bypass, RNONE handling and a one-register-per-cycle clear engine.
module y86_regfile_mp
  import y86_pkg::*;
#(
  parameter int unsigned       DATA_W   = DATA_W_DEF,
  parameter int unsigned       ADDR_W   = ADDR_W_DEF,
  parameter int unsigned       NUM_REGS = 15,
  parameter int unsigned       NUM_RD   = 2,
  parameter int unsigned       NUM_WR   = 2,
  parameter int unsigned       BYPASS   = 1,
  parameter logic [ADDR_W-1:0] RNONE    = ADDR_W'(RNONE_IDX)
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [NUM_WR-1:0]        wr_en,
  input  logic [NUM_WR*ADDR_W-1:0] wr_addr,
  input  logic [NUM_WR*DATA_W-1:0] wr_data,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  input  logic                     clr_req,
  output logic                     clr_busy,
  output logic                     clr_done
);

  localparam int unsigned CNT_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NUM_REGS - 1);
  localparam logic [ADDR_W:0]  NREGS_X  = (ADDR_W + 1)'(NUM_REGS);

  if ((NUM_REGS > (2 ** ADDR_W) - 1) || (int'(RNONE) < int'(NUM_REGS))) begin : g_bad_cfg
    $error("y86_regfile_mp: NUM_REGS must leave RNONE outside the implemented range");
  end

  logic [DATA_W-1:0] r_regs [NUM_REGS];
  clr_state_e        r_state;
  logic [CNT_W-1:0]  r_cnt;

  logic              w_wr_hit  [NUM_REGS];
  logic [DATA_W-1:0] w_wr_data [NUM_REGS];
  logic              w_byp_hit [NUM_RD];
  logic [DATA_W-1:0] w_byp_data[NUM_RD];

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_wr
    y86_wr_arbiter #(
      .NUM_WR (NUM_WR),
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W)
    ) u_arb (
      .i_wr_en   (wr_en),
      .i_wr_addr (wr_addr),
      .i_wr_data (wr_data),
      .i_idx     (ADDR_W'(g)),
      .o_hit     (w_wr_hit[g]),
      .o_data    (w_wr_data[g])
    );
  end

  for (genvar g = 0; g < NUM_RD; g++) begin : g_byp
    y86_wr_arbiter #(
      .NUM_WR (NUM_WR),
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W)
    ) u_arb (
      .i_wr_en   (wr_en),
      .i_wr_addr (wr_addr),
      .i_wr_data (wr_data),
      .i_idx     (rd_addr[g*ADDR_W +: ADDR_W]),
      .o_hit     (w_byp_hit[g]),
      .o_data    (w_byp_data[g])
    );
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
      r_state <= CLR_IDLE;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        CLR_IDLE: begin
          for (int unsigned i = 0; i < NUM_REGS; i++) begin
            if (w_wr_hit[i]) r_regs[i] <= w_wr_data[i];
          end
          if (clr_req) begin
            r_state <= CLR_CLEAR;
            r_cnt   <= '0;
          end
        end
        CLR_CLEAR: begin
          r_regs[r_cnt] <= '0;
          r_cnt         <= r_cnt + 1'b1;
          if (r_cnt == CNT_LAST) r_state <= CLR_DONE;
        end
        CLR_DONE: r_state <= CLR_IDLE;
        default:  r_state <= CLR_IDLE;
      endcase
    end
  end

  // Illegal indices (RNONE included) read zero even if a write port matches them.
  always_comb begin
    rd_data = '0;
    for (int unsigned j = 0; j < NUM_RD; j++) begin
      if ((r_state == CLR_IDLE) &&
          (rd_addr[j*ADDR_W +: ADDR_W] != RNONE) &&
          ({1'b0, rd_addr[j*ADDR_W +: ADDR_W]} < NREGS_X)) begin
        if ((BYPASS != 0) && w_byp_hit[j])
          rd_data[j*DATA_W +: DATA_W] = w_byp_data[j];
        else
          rd_data[j*DATA_W +: DATA_W] = r_regs[rd_addr[j*ADDR_W +: ADDR_W]];
      end
    end
  end

  assign clr_busy = (r_state != CLR_IDLE);
  assign clr_done = (r_state == CLR_DONE);

endmodule

// File: tb/tb_y86_regfile_mp.sv
// Scoreboard bench for y86_regfile_mp: bypass and non-bypass instances share
// stimulus; expectations are queued by the driver and checked at negedge.
module tb_y86_regfile_mp;

  logic         clock;
  logic         reset;
  logic [1:0]   wr_en;
  logic [7:0]   wr_addr;
  logic [127:0] wr_data;
  logic [7:0]   rd_addr;
  logic         clr_req;
  logic [127:0] rd_data_bp, rd_data_nb;
  logic         busy_bp, done_bp, busy_nb, done_nb;

  y86_regfile_mp #(.BYPASS(1)) u_dut_bp (
    .clock(clock), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .rd_addr(rd_addr), .rd_data(rd_data_bp),
    .clr_req(clr_req), .clr_busy(busy_bp), .clr_done(done_bp));

  y86_regfile_mp #(.BYPASS(0)) u_dut_nb (
    .clock(clock), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .rd_addr(rd_addr), .rd_data(rd_data_nb),
    .clr_req(clr_req), .clr_busy(busy_nb), .clr_done(done_nb));

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // kind: 0/1 = bypass rd port 0/1, 2/3 = non-bypass rd port 0/1,
  //       4 = clr_busy, 5 = clr_done, 6 = non-bypass clr_busy
  typedef struct {
    string       name;
    int          kind;
    logic [63:0] exp;
  } exp_t;

  exp_t q[$];
  int   n_total = 0;
  int   n_pass  = 0;

  function automatic logic [63:0] actual(input int kind);
    case (kind)
      0: return rd_data_bp[63:0];
      1: return rd_data_bp[127:64];
      2: return rd_data_nb[63:0];
      3: return rd_data_nb[127:64];
      4: return {63'd0, busy_bp};
      5: return {63'd0, done_bp};
      default: return {63'd0, busy_nb};
    endcase
  endfunction

  initial begin
    exp_t e;
    logic [63:0] a;
    forever begin
      @(negedge clock);
      while (q.size() > 0) begin
        e = q.pop_front();
        a = actual(e.kind);
        n_total++;
        if (a === e.exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", e.name, a, e.exp);
      end
    end
  end

  task automatic expect_v(input string name, input int kind, input logic [63:0] v);
    exp_t e;
    e.name = name; e.kind = kind; e.exp = v;
    q.push_back(e);
  endtask

  task automatic expect_rd(input string name, input int port, input logic [63:0] v_bp,
                           input logic [63:0] v_nb);
    expect_v({name, "_bp"}, port, v_bp);
    expect_v({name, "_nb"}, port + 2, v_nb);
  endtask

  task automatic expect_clr(input string name, input logic b, input logic d);
    expect_v({name, "_busy"}, 4, {63'd0, b});
    expect_v({name, "_done"}, 5, {63'd0, d});
    expect_v({name, "_busy_nb"}, 6, {63'd0, b});
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic wr(input logic [1:0] en, input logic [3:0] a0, input logic [63:0] d0,
                    input logic [3:0] a1, input logic [63:0] d1);
    wr_en   = en;
    wr_addr = {a1, a0};
    wr_data = {d1, d0};
  endtask

  task automatic rd(input logic [3:0] a0, input logic [3:0] a1);
    rd_addr = {a1, a0};
  endtask

  initial begin
    reset = 1'b0; clr_req = 1'b0;
    wr(2'b00, 4'd0, 64'd0, 4'd0, 64'd0);
    rd(4'd3, 4'd5);
    expect_rd("rst_rd0", 0, 64'd0, 64'd0);
    expect_clr("rst", 1'b0, 1'b0);
    tick(); tick();
    reset = 1'b1;

    // Basic write with same-cycle bypass
    wr(2'b01, 4'd3, 64'h1234, 4'd0, 64'd0);
    rd(4'd3, 4'hF);
    expect_rd("wr_r3_same", 0, 64'h1234, 64'd0);
    tick();
    // RNONE write dropped, RNONE read zero even with matching write port
    wr(2'b01, 4'hF, 64'hDEAD, 4'd0, 64'd0);
    expect_rd("wr_r3_next", 0, 64'h1234, 64'h1234);
    expect_rd("rnone_rd_byp", 1, 64'd0, 64'd0);
    tick();
    // Collision on R5: port 0 wins
    wr(2'b11, 4'd5, 64'hAA, 4'd5, 64'hBB);
    rd(4'd5, 4'hF);
    expect_rd("coll_same", 0, 64'hAA, 64'd0);
    expect_rd("rnone_rd", 1, 64'd0, 64'd0);
    tick();
    // Distinct writes on one edge
    wr(2'b11, 4'd1, 64'd1, 4'd2, 64'd2);
    rd(4'd5, 4'd2);
    expect_rd("coll_next", 0, 64'hAA, 64'hAA);
    expect_rd("dist_r2_same", 1, 64'd2, 64'd0);
    tick();
    wr(2'b10, 4'd0, 64'd0, 4'd3, 64'd5);
    rd(4'd1, 4'd2);
    expect_rd("dist_r1", 0, 64'd1, 64'd1);
    expect_rd("dist_r2", 1, 64'd2, 64'd2);
    tick();
    wr(2'b00, 4'd0, 64'd0, 4'd0, 64'd0);
    rd(4'd3, 4'hE);
    expect_rd("r3_eq5", 0, 64'd5, 64'd5);
    tick();
    // Asynchronous reset mid-run
    reset = 1'b0;
    rd(4'd3, 4'd2);
    expect_rd("async_rst_r3", 0, 64'd0, 64'd0);
    expect_rd("async_rst_r2", 1, 64'd0, 64'd0);
    expect_clr("async_rst", 1'b0, 1'b0);
    tick();
    reset = 1'b1;

    // Preload R0..R14 with 0x100+i
    for (int i = 0; i < 15; i += 2) begin
      wr((i == 14) ? 2'b01 : 2'b11, 4'(i), 64'h100 + 64'(i), 4'(i + 1), 64'h101 + 64'(i));
      tick();
    end
    wr(2'b00, 4'd0, 64'd0, 4'd0, 64'd0);
    rd(4'd0, 4'd14);
    expect_rd("pre_r0", 0, 64'h100, 64'h100);
    expect_rd("pre_r14", 1, 64'h10E, 64'h10E);
    tick();
    // clr_req with a same-cycle write: write commits, then gets cleared
    clr_req = 1'b1;
    wr(2'b01, 4'd7, 64'h77, 4'd0, 64'd0);
    expect_clr("clr_req_cyc", 1'b0, 1'b0);
    tick();
    clr_req = 1'b0;
    wr(2'b00, 4'd0, 64'd0, 4'd0, 64'd0);
    rd(4'd4, 4'd0);
    for (int c = 1; c <= 16; c++) begin
      if (c == 2) begin
        clr_req = 1'b1;
        wr(2'b01, 4'd4, 64'h44, 4'd0, 64'd0);
      end else begin
        clr_req = 1'b0;
        wr(2'b00, 4'd0, 64'd0, 4'd0, 64'd0);
      end
      expect_clr($sformatf("clr_c%0d", c), 1'b1, (c == 16) ? 1'b1 : 1'b0);
      expect_rd($sformatf("clr_rd_c%0d", c), 0, 64'd0, 64'd0);
      tick();
    end
    clr_req = 1'b0;
    wr(2'b00, 4'd0, 64'd0, 4'd0, 64'd0);
    expect_clr("clr_after", 1'b0, 1'b0);
    for (int i = 0; i < 15; i++) begin
      rd(4'(i), 4'hF);
      expect_rd($sformatf("clr_r%0d", i), 0, 64'd0, 64'd0);
      tick();
    end

    // Reset in the middle of a clear (counter = 7)
    wr(2'b11, 4'd9, 64'h99, 4'd2, 64'h22);
    tick();
    wr(2'b00, 4'd0, 64'd0, 4'd0, 64'd0);
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    repeat (7) tick();
    rd(4'd9, 4'd2);
    expect_clr("mid_clr_busy", 1'b1, 1'b0);
    tick();
    reset = 1'b0;
    expect_clr("mid_rst", 1'b0, 1'b0);
    expect_rd("mid_rst_r9", 0, 64'd0, 64'd0);
    tick();
    reset = 1'b1;
    wr(2'b01, 4'd2, 64'd9, 4'd0, 64'd0);
    rd(4'd2, 4'd9);
    expect_rd("post_rst_wr_same", 0, 64'd9, 64'd0);
    expect_rd("post_rst_r9", 1, 64'd0, 64'd0);
    tick();
    wr(2'b00, 4'd0, 64'd0, 4'd0, 64'd0);
    for (int c = 0; c < 10; c++) begin
      expect_rd($sformatf("post_rst_r2_%0d", c), 0, 64'd9, 64'd9);
      expect_clr($sformatf("post_rst_nodone_%0d", c), 1'b0, 1'b0);
      tick();
    end

    if (q.size() != 0) begin
      $display("FAIL scoreboard_drain: got %0d pending expected 0", q.size());
      n_total += q.size();
    end
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/y86_regfile_mp.md
Name: y86_regfile_mp

Overview:
Parametrised multi-port register file for the Y86-64 datapath; the next generation of the current two-write-port register file.
- Any number of read and write ports, with fixed write priority when ports collide.
- Optional same-cycle write-to-read bypass.
- RNONE (4'hF) handling: reads return zero, writes are dropped.
- A sequenced clear engine, so the core can flush architectural state without asserting reset.
- Sits between decode (reads) and the E/M writeback paths (writes).

Parameters:
DATA_W, 64, register width in bits
ADDR_W, 4, register index width
NUM_REGS, 15, implemented registers (indices 0..NUM_REGS-1)
NUM_RD, 2, read ports
NUM_WR, 2, write ports; port 0 has highest priority
BYPASS, 1, 1 = same-cycle write data forwarded to reads; 0 = reads see array only
RNONE, 4'hF, "no register" index

Ports:
clock  in  1  rising-edge clock
reset  in  1  asynchronous, active-low reset
wr_en  in  NUM_WR  per-port write enable
wr_addr  in  NUM_WR*ADDR_W  packed write indices, port 0 in LSBs
wr_data  in  NUM_WR*DATA_W  packed write data, port 0 in LSBs
rd_addr  in  NUM_RD*ADDR_W  packed read indices
rd_data  out  NUM_RD*DATA_W  packed read data, combinational
clr_req  in  1  single-cycle request to clear all registers
clr_busy  out  1  high while clear sequence runs
clr_done  out  1  one-cycle pulse when clear completes

Behaviour:
- **Reset.** reset low (async): all registers = 0, FSM = IDLE, clr_busy = 0, clr_done = 0, clear counter = 0. Registers must be in the async reset branch; no separate reset process.
- **Writes.**
  - Commit at posedge clock when wr_en[i]=1, FSM=IDLE and wr_addr[i] < NUM_REGS.
  - Writes to RNONE or any index >= NUM_REGS are silently dropped.
  - Write collision: if several enabled ports target the same index, the lowest-numbered port wins. Port 0 = E-stage, port 1 = M-stage; the younger instruction wins.
  - Writes to distinct indices on the same cycle all commit.
- **Reads.**
  - Combinational, zero latency.
  - rd_data[j] = 0 when rd_addr[j] == RNONE or rd_addr[j] >= NUM_REGS.
  - BYPASS=1 and some enabled, legal write port targets rd_addr[j] in the same cycle: return that port's wr_data, using the same priority as writes. Otherwise return the array value.
  - BYPASS=0: reads return the array value; a write becomes visible the cycle after its clock edge.
- **Clear FSM.** States IDLE, CLEAR, DONE.
  - IDLE -> CLEAR on clr_req=1; counter loads 0.
  - CLEAR: one register zeroed per cycle at index = counter; counter increments.
  - CLEAR -> DONE after index NUM_REGS-1 is zeroed, so CLEAR lasts NUM_REGS cycles.
  - DONE: clr_done = 1 for exactly one cycle, then -> IDLE.
  - clr_busy = 1 in CLEAR and DONE.
  - All writes are ignored in CLEAR and DONE, and are not queued.
  - Reads in CLEAR and DONE return 0 regardless of bypass.
  - clr_req outside IDLE is ignored.
  - clr_req and wr_en in the same IDLE cycle: the write commits on that edge and the clear sequence then zeroes it.
- **Reset during CLEAR or DONE:** immediate return to IDLE with all registers 0; no clr_done pulse.
- **Counter width:** $clog2(NUM_REGS).
- **Elaboration errors:** NUM_REGS > 2**ADDR_W-1, or RNONE < NUM_REGS.

Decomposition:
- Shared package y86_pkg:
  - RNONE and register index constants (RRAX..R14).
  - ADDR_W/DATA_W defaults.
  - enum type for clear FSM states.
- One natural sub-module, y86_wr_arbiter:
  - Combinational priority select over the write ports for a given index.
  - Returns hit flag and selected data.
  - Instantiated per register for writes and per read port for bypass.

Test Plan:
- **Reset:** reset low mid-run after writing R3=5 -> all rd_data 0 immediately; clr_busy=0, clr_done=0.
- **Write/read and RNONE:** write port0 R3=64'h1234 -> next cycle rd_addr=3 reads 64'h1234. Write to RNONE -> no change; rd_addr=4'hF reads 0.
- **Collision:** port0 and port1 both write R5 (0xAA / 0xBB) -> R5 = 0xAA. Same-cycle read with BYPASS=1 returns 0xAA; with BYPASS=0 returns the old value, then 0xAA next cycle.
- **Distinct writes:** port0 R1=1, port1 R2=2 on the same edge -> both commit.
- **Clear:** preload R0..R14 with nonzero values, pulse clr_req.
  - Expect clr_busy high for 16 cycles and clr_done pulse on cycle 16; all registers then read 0.
  - Writes issued during busy are lost; clr_req during busy is ignored.
- **Reset mid-clear:** assert reset at counter=7 -> IDLE, all zero, no clr_done. A subsequent write of R2=9 works on the first cycle after release.
